// File: rtl/eq_run_gen.sv
// rtl/eq_run_gen.sv - stimulus source for the equal-input-run detector, with expected z.
// Optional EQ_RUN_ZCOUNT_EN adds o_zcnt, the per-burst count of z_exp cycles.
module eq_run_gen #(
  parameter int LEN_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_run_len,
  input  logic             i_pol,
  input  logic             i_brk,
  output logic             o_w1,
  output logic             o_w2,
  output logic             o_valid,
  output logic             o_z_exp,
  output logic             o_busy,
`ifdef EQ_RUN_ZCOUNT_EN
  output logic [7:0]       o_zcnt,
`endif
  output logic             o_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_BRK  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] w_cnt_nxt;
  logic             r_pol;
  logic             w_pol_nxt;
  logic             r_brk;
  logic             w_brk_nxt;
  logic [1:0]       r_hist;
  logic [1:0]       w_hist_nxt;
  logic             w_accept;
  logic             w_w1_nxt;
  logic             w_w2_nxt;
  logic             w_valid_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_eq_nxt;
  logic             w_z_nxt;

  // r_cnt holds the number of run pairs still to come after the one on the outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pol_nxt   = r_pol;
    w_brk_nxt   = r_brk;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_accept  = 1'b1;
          w_pol_nxt = i_pol;
          w_brk_nxt = i_brk;
          if (i_run_len != '0) begin
            w_state_nxt = S_RUN;
            w_cnt_nxt   = i_run_len - 1'b1;
          end else if (i_brk) begin
            w_state_nxt = S_BRK;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else if (r_brk) begin
          w_state_nxt = S_BRK;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      S_BRK:   w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    w_w1_nxt    = 1'b0;
    w_w2_nxt    = 1'b1;
    w_valid_nxt = 1'b0;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    case (w_state_nxt)
      S_RUN: begin
        w_w1_nxt    = w_pol_nxt;
        w_w2_nxt    = w_pol_nxt;
        w_valid_nxt = 1'b1;
        w_busy_nxt  = 1'b1;
      end
      S_BRK: begin
        w_w1_nxt    = ~w_pol_nxt;
        w_w2_nxt    = w_pol_nxt;
        w_valid_nxt = 1'b1;
        w_busy_nxt  = 1'b1;
      end
      S_DONE: begin
        w_busy_nxt = 1'b1;
        w_done_nxt = 1'b1;
      end
      default: ;
    endcase
    w_eq_nxt   = w_valid_nxt & (w_w1_nxt == w_w2_nxt);
    w_z_nxt    = w_eq_nxt & (r_hist == 2'd3);
    w_hist_nxt = 2'd0;
    if (w_eq_nxt) begin
      w_hist_nxt = (r_hist == 2'd3) ? 2'd3 : r_hist + 2'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pol   <= 1'b0;
      r_brk   <= 1'b0;
      r_hist  <= 2'd0;
      o_w1    <= 1'b0;
      o_w2    <= 1'b1;
      o_valid <= 1'b0;
      o_z_exp <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pol   <= w_pol_nxt;
      r_brk   <= w_brk_nxt;
      r_hist  <= w_hist_nxt;
      o_w1    <= w_w1_nxt;
      o_w2    <= w_w2_nxt;
      o_valid <= w_valid_nxt;
      o_z_exp <= w_z_nxt;
      o_busy  <= w_busy_nxt;
      o_done  <= w_done_nxt;
    end
  end

`ifdef EQ_RUN_ZCOUNT_EN
  // Tracks the z_exp value being registered alongside it; held after DONE.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_zcnt <= 8'd0;
    end else if (w_accept) begin
      o_zcnt <= 8'd0;
    end else if (w_z_nxt && (o_zcnt != 8'hff)) begin
      o_zcnt <= o_zcnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_eq_run_gen.sv
// tb/tb_eq_run_gen.sv - scoreboard bench for eq_run_gen (optionally with EQ_RUN_ZCOUNT_EN).
module tb_eq_run_gen;
  localparam int LEN_W = 4;
  localparam logic [5:0] IDLE_OUT = 6'b010000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] run_len = '0;
  logic             pol = 1'b0;
  logic             brk = 1'b0;
  logic             o_w1, o_w2, o_valid, o_z_exp, o_busy, o_done;
`ifdef EQ_RUN_ZCOUNT_EN
  logic [7:0]       o_zcnt;
`endif
  logic [5:0]       w_obs;

  int n_cmp = 0;
  int n_bad = 0;
  logic [5:0] q_exp[$];

  eq_run_gen #(.LEN_W(LEN_W)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_start  (start),
    .i_run_len(run_len),
    .i_pol    (pol),
    .i_brk    (brk),
    .o_w1     (o_w1),
    .o_w2     (o_w2),
    .o_valid  (o_valid),
    .o_z_exp  (o_z_exp),
    .o_busy   (o_busy),
`ifdef EQ_RUN_ZCOUNT_EN
    .o_zcnt   (o_zcnt),
`endif
    .o_done   (o_done)
  );

  assign w_obs = {o_w1, o_w2, o_valid, o_z_exp, o_busy, o_done};

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected per-cycle outputs {w1,w2,valid,z_exp,busy,done} for one burst.
  task automatic push_burst(input int len, input logic p, input logic b);
    for (int k = 1; k <= len; k++) begin
      q_exp.push_back({p, p, 1'b1, (k >= 4), 1'b1, 1'b0});
    end
    if (b) q_exp.push_back({~p, p, 1'b1, 1'b0, 1'b1, 1'b0});
    q_exp.push_back(6'b010011);
    q_exp.push_back(IDLE_OUT);
  endtask

  task automatic run_burst(input int len, input logic p, input logic b, input bit hold_start);
    logic [5:0] e;
    int idx;
    @(negedge clk);
    run_len = len[LEN_W-1:0];
    pol = p;
    brk = b;
    start = 1'b1;
    push_burst(len, p, b);
    idx = 0;
    while (q_exp.size() > 0) begin
      @(negedge clk);
      if (!hold_start) start = 1'b0;
      idx++;
      e = q_exp.pop_front();
      check_val($sformatf("burst_len%0d_b%0d_cyc%0d", len, b, idx), {26'd0, w_obs}, {26'd0, e});
      if (e[0]) start = 1'b0;
    end
`ifdef EQ_RUN_ZCOUNT_EN
    check_val($sformatf("zcnt_len%0d", len), {24'd0, o_zcnt}, (len >= 4) ? len - 3 : 0);
`endif
  endtask

  initial begin
    logic [5:0] e;
    repeat (2) @(negedge clk);
    check_val("reset_held", {26'd0, w_obs}, {26'd0, IDLE_OUT});
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val($sformatf("idle_%0d", i), {26'd0, w_obs}, {26'd0, IDLE_OUT});
    end

    run_burst(5, 1'b1, 1'b1, 1'b0);
    run_burst(3, 1'b0, 1'b0, 1'b0);
    run_burst(0, 1'b0, 1'b0, 1'b0);
    run_burst(0, 1'b1, 1'b1, 1'b0);
    run_burst(15, 1'b1, 1'b0, 1'b1);
    run_burst(6, 1'b0, 1'b1, 1'b0);

    // Abandon a burst with reset during pair 3.
    @(negedge clk);
    run_len = 4'd15;
    pol = 1'b1;
    brk = 1'b1;
    start = 1'b1;
    push_burst(15, 1'b1, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      start = 1'b0;
      e = q_exp.pop_front();
      check_val($sformatf("pre_rst_pair%0d", i), {26'd0, w_obs}, {26'd0, e});
    end
    #1 rst = 1'b1;
    #1 check_val("rst_async", {26'd0, w_obs}, {26'd0, IDLE_OUT});
    q_exp.delete();
    @(negedge clk);
    check_val("rst_hold", {26'd0, w_obs}, {26'd0, IDLE_OUT});
`ifdef EQ_RUN_ZCOUNT_EN
    check_val("rst_zcnt", {24'd0, o_zcnt}, 32'd0);
`endif
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val($sformatf("post_rst_idle%0d", i), {26'd0, w_obs}, {26'd0, IDLE_OUT});
    end
    run_burst(4, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule

// File: doc/eq_run_gen.md
Name: eq_run_gen

Overview:
- Stimulus transmitter for the team's equal-input-run detector: drives the w1/w2 pair that detector samples.
- On command, emits a burst of N "equal" pairs (w1 == w2), optionally followed by one "unequal" break pair.
- Also outputs z_exp, the cycle-accurate expected Mealy output of the detector (z = 1 on the 4th and later consecutive equal pair). Benches compare it against the detector's z.

Parameters:
LEN_W, 4, width of the run-length command; maximum burst length is 2^LEN_W - 1.

Ports:
Clock  input  1  single clock, rising edge.
Reset  input  1  asynchronous, active-high reset.
start  input  1  command strobe; sampled only in IDLE.
run_len  input  LEN_W  number of equal pairs in the burst; latched on an accepted start.
pol  input  1  value driven on both w1 and w2 during equal pairs; latched on an accepted start.
brk  input  1  1 = append one unequal break pair after the run; latched on an accepted start.
w1  output  1  registered stimulus bit 1.
w2  output  1  registered stimulus bit 2.
valid  output  1  1 while w1/w2 carry a burst pair (run or break).
z_exp  output  1  expected detector output for the current pair.
busy  output  1  high from the first burst cycle through DONE.
done  output  1  one-cycle pulse at end of burst.

Behaviour:
- Reset (asynchronous, active-high): immediately forces state = IDLE, w1 = 0, w2 = 1, valid = 0, z_exp = 0, busy = 0, done = 0, run counter = 0, equal-history counter = 0. Applies mid-burst too; the burst is abandoned and there is no done pulse.
- All outputs are registered.
- States: IDLE, RUN, BRK, DONE.
- IDLE:
  - Drives the unequal pair w1 = 0, w2 = 1 with valid = 0, so the detector sits in its initial state between bursts.
  - start = 1 at a rising edge latches run_len, pol and brk.
  - Next state: RUN if run_len != 0; else BRK if brk = 1; else DONE.
  - Latency: the first burst pair appears in the cycle after the edge that sampled start.
- RUN:
  - Each cycle drives w1 = w2 = pol, valid = 1, busy = 1, and decrements the run counter.
  - After the run_len-th pair: go to BRK if brk = 1, else DONE.
- BRK:
  - One cycle of w1 = ~pol, w2 = pol, valid = 1, z_exp = 0.
  - Clears the equal-history counter; next state DONE.
- DONE:
  - One cycle with done = 1, busy = 1, valid = 0, and the idle pair (0, 1).
  - Next state IDLE; a new start is accepted on the following edge at the earliest.
- start while not in IDLE is ignored and has no side effects.
- z_exp model:
  - A 2-bit equal-history counter saturates at 3. It increments on each valid equal pair and is cleared on any unequal pair, including idle.
  - z_exp = valid & (w1 == w2) & (history == 3, evaluated before the increment).
  - So within a burst, pair k (1-based) has z_exp = 1 iff k >= 4.
- Widths: the run counter is LEN_W bits and never wraps; run_len = 2^LEN_W - 1 yields exactly that many pairs.

Optional Feature:
- Macro: EQ_RUN_ZCOUNT_EN.
- Defined:
  - Adds output zcnt[7:0], a count of cycles with z_exp = 1 in the current burst.
  - Cleared to 0 on reset and on an accepted start; saturates at 255; holds its value after DONE until the next accepted start.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset released, no start for 5 cycles -> w1 = 0, w2 = 1, valid = 0, busy = 0, done = 0, z_exp = 0 throughout.
- start with run_len = 5, pol = 1, brk = 1 -> cycles 1-5: (1,1), valid = 1, z_exp = 0,0,0,1,1; cycle 6: (0,1), valid = 1, z_exp = 0; cycle 7: done = 1; cycle 8: IDLE, busy = 0.
- start with run_len = 3, pol = 0, brk = 0 -> three (0,0) pairs all with z_exp = 0, then DONE; if EQ_RUN_ZCOUNT_EN, zcnt = 0.
- start with run_len = 0, brk = 0 -> no valid cycles; done pulse in cycle 1. Repeat with run_len = 0, brk = 1 -> a single break pair, then done.
- start with run_len = 15, pol = 1 -> 15 pairs, z_exp high on pairs 4-15 (12 cycles; zcnt = 12). start re-asserted mid-burst is ignored.
- Reset asserted during RUN pair 3 -> outputs return to idle values immediately and no done pulse occurs. A fresh start with run_len = 4 then gives z_exp only on pair 4.
